// File: rtl/axi4l_mst_cmd.sv
`default_nettype none
// ============================================================================
// Module   : axi4l_mst_cmd
// Purpose  : Command-driven AXI4-Lite master. Each accepted command becomes
//            one AXI4-Lite read or write. The bus response, the RESP code and
//            the latency in cycles are returned on a valid/ready response
//            port. Only one transaction is outstanding at a time.
// Revision : 1.0 - initial release
// ============================================================================
module axi4l_mst_cmd #(
  parameter int C_ADDR_WIDTH = 12,
  parameter int C_DATA_WIDTH = 32
) (
  input  logic                      aclk,
  input  logic                      aresetn,
  // command port
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic                      cmd_write,
  input  logic [C_ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [C_DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [C_DATA_WIDTH/8-1:0] cmd_wstrb,
  // response port
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [C_DATA_WIDTH-1:0]   rsp_rdata,
  output logic [1:0]                rsp_resp,
  output logic [15:0]               rsp_cycles,
  // AW channel
  output logic [C_ADDR_WIDTH-1:0]   m_axi_awaddr,
  output logic [2:0]                m_axi_awprot,
  output logic                      m_axi_awvalid,
  input  logic                      m_axi_awready,
  // W channel
  output logic [C_DATA_WIDTH-1:0]   m_axi_wdata,
  output logic [C_DATA_WIDTH/8-1:0] m_axi_wstrb,
  output logic                      m_axi_wvalid,
  input  logic                      m_axi_wready,
  // B channel
  input  logic [1:0]                m_axi_bresp,
  input  logic                      m_axi_bvalid,
  output logic                      m_axi_bready,
  // AR channel
  output logic [C_ADDR_WIDTH-1:0]   m_axi_araddr,
  output logic [2:0]                m_axi_arprot,
  output logic                      m_axi_arvalid,
  input  logic                      m_axi_arready,
  // R channel
  input  logic [C_DATA_WIDTH-1:0]   m_axi_rdata,
  input  logic [1:0]                m_axi_rresp,
  input  logic                      m_axi_rvalid,
  output logic                      m_axi_rready
);

  localparam int          C_STRB_WIDTH = C_DATA_WIDTH / 8;
  localparam logic [15:0] C_CYCLES_MAX = 16'hFFFF;

  // Only 32- and 64-bit AXI4-Lite data buses exist; refuse anything else.
  if ((C_DATA_WIDTH != 32) && (C_DATA_WIDTH != 64)) begin : g_bad_data_width
    $error("axi4l_mst_cmd: C_DATA_WIDTH must be 32 or 64");
  end

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WREQ  = 3'd1,
    S_WRESP = 3'd2,
    S_RREQ  = 3'd3,
    S_RRESP = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic [C_ADDR_WIDTH-1:0] r_awaddr;
  logic                    r_awvalid;
  logic [C_DATA_WIDTH-1:0] r_wdata;
  logic [C_STRB_WIDTH-1:0] r_wstrb;
  logic                    r_wvalid;
  logic                    r_bready;
  logic [C_ADDR_WIDTH-1:0] r_araddr;
  logic                    r_arvalid;
  logic                    r_rready;
  logic                    r_rsp_valid;
  logic [C_DATA_WIDTH-1:0] r_rsp_rdata;
  logic [1:0]              r_rsp_resp;
  logic [15:0]             r_rsp_cycles;

  logic w_accept;
  logic w_aw_done;
  logic w_w_done;
  logic w_busy;

  // A command is taken only while idle; cmd_ready is purely a state decode.
  assign w_accept  = (r_state == S_IDLE) && cmd_valid;
  // A channel counts as done once its valid has dropped or is being accepted now.
  assign w_aw_done = !r_awvalid || m_axi_awready;
  assign w_w_done  = !r_wvalid  || m_axi_wready;
  assign w_busy    = (r_state == S_WREQ) || (r_state == S_WRESP) ||
                     (r_state == S_RREQ) || (r_state == S_RRESP);

  // State register.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state decode for the transaction sequence.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (cmd_valid) w_state_next = cmd_write ? S_WREQ : S_RREQ;
      S_WREQ:  if (w_aw_done && w_w_done) w_state_next = S_WRESP;
      S_WRESP: if (m_axi_bvalid) w_state_next = S_DONE;
      S_RREQ:  if (m_axi_arready) w_state_next = S_RRESP;
      S_RRESP: if (m_axi_rvalid) w_state_next = S_DONE;
      S_DONE:  if (rsp_ready) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // AW/W payload captured at accept; each valid drops independently after its handshake.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_awaddr  <= '0;
      r_awvalid <= 1'b0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
      r_wvalid  <= 1'b0;
    end else if (w_accept && cmd_write) begin
      r_awaddr  <= cmd_addr;
      r_awvalid <= 1'b1;
      r_wdata   <= cmd_wdata;
      r_wstrb   <= cmd_wstrb;
      r_wvalid  <= 1'b1;
    end else begin
      if (r_awvalid && m_axi_awready) r_awvalid <= 1'b0;
      if (r_wvalid && m_axi_wready)   r_wvalid  <= 1'b0;
    end
  end

  // AR payload captured at accept; arvalid held until arready.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_araddr  <= '0;
      r_arvalid <= 1'b0;
    end else if (w_accept && !cmd_write) begin
      r_araddr  <= cmd_addr;
      r_arvalid <= 1'b1;
    end else if (r_arvalid && m_axi_arready) begin
      r_arvalid <= 1'b0;
    end
  end

  // Registered readies and rsp_valid follow the state being entered.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_bready    <= 1'b0;
      r_rready    <= 1'b0;
      r_rsp_valid <= 1'b0;
    end else begin
      r_bready    <= (w_state_next == S_WRESP);
      r_rready    <= (w_state_next == S_RRESP);
      r_rsp_valid <= (w_state_next == S_DONE);
    end
  end

  // Capture the bus response; writes report zero read data.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_rsp_rdata <= '0;
      r_rsp_resp  <= 2'b00;
    end else if ((r_state == S_WRESP) && m_axi_bvalid) begin
      r_rsp_rdata <= '0;
      r_rsp_resp  <= m_axi_bresp;
    end else if ((r_state == S_RRESP) && m_axi_rvalid) begin
      r_rsp_rdata <= m_axi_rdata;
      r_rsp_resp  <= m_axi_rresp;
    end
  end

  // Latency counter: cleared at accept, counts every bus-busy cycle, saturates.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_rsp_cycles <= 16'd0;
    end else if (w_accept) begin
      r_rsp_cycles <= 16'd0;
    end else if (w_busy && (r_rsp_cycles != C_CYCLES_MAX)) begin
      r_rsp_cycles <= r_rsp_cycles + 16'd1;
    end
  end

  assign cmd_ready     = (r_state == S_IDLE);
  assign rsp_valid     = r_rsp_valid;
  assign rsp_rdata     = r_rsp_rdata;
  assign rsp_resp      = r_rsp_resp;
  assign rsp_cycles    = r_rsp_cycles;
  assign m_axi_awaddr  = r_awaddr;
  assign m_axi_awprot  = 3'b000;
  assign m_axi_awvalid = r_awvalid;
  assign m_axi_wdata   = r_wdata;
  assign m_axi_wstrb   = r_wstrb;
  assign m_axi_wvalid  = r_wvalid;
  assign m_axi_bready  = r_bready;
  assign m_axi_araddr  = r_araddr;
  assign m_axi_arprot  = 3'b000;
  assign m_axi_arvalid = r_arvalid;
  assign m_axi_rready  = r_rready;

endmodule
`default_nettype wire

// File: tb/tb_axi4l_mst_cmd.sv
`default_nettype none
// ============================================================================
// Module   : tb_axi4l_mst_cmd
// Purpose  : Directed self-checking bench for axi4l_mst_cmd with a scripted
//            AXI4-Lite slave and hand-computed expected timing and data.
// Revision : 1.0 - initial release
// ============================================================================
module tb_axi4l_mst_cmd;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_write = 1'b0;
  logic [11:0] cmd_addr = '0;
  logic [31:0] cmd_wdata = '0;
  logic [3:0]  cmd_wstrb = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic [15:0] rsp_cycles;
  logic [11:0] m_axi_awaddr;
  logic [2:0]  m_axi_awprot;
  logic        m_axi_awvalid;
  logic        m_axi_awready = 1'b0;
  logic [31:0] m_axi_wdata;
  logic [3:0]  m_axi_wstrb;
  logic        m_axi_wvalid;
  logic        m_axi_wready = 1'b0;
  logic [1:0]  m_axi_bresp = '0;
  logic        m_axi_bvalid = 1'b0;
  logic        m_axi_bready;
  logic [11:0] m_axi_araddr;
  logic [2:0]  m_axi_arprot;
  logic        m_axi_arvalid;
  logic        m_axi_arready = 1'b0;
  logic [31:0] m_axi_rdata = '0;
  logic [1:0]  m_axi_rresp = '0;
  logic        m_axi_rvalid = 1'b0;
  logic        m_axi_rready;

  int total = 0;
  int bad   = 0;

  axi4l_mst_cmd #(.C_ADDR_WIDTH(12), .C_DATA_WIDTH(32)) u_dut (
    .aclk(aclk), .aresetn(aresetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_resp(rsp_resp), .rsp_cycles(rsp_cycles),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awprot(m_axi_awprot),
    .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
    .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
    .m_axi_araddr(m_axi_araddr), .m_axi_arprot(m_axi_arprot),
    .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
    .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
  );

  // 100 MHz clock.
  always #5 aclk = ~aclk;

  // Single comparison point: counts every check and reports any mismatch.
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic slave_idle();
    m_axi_awready = 1'b0; m_axi_wready = 1'b0; m_axi_bvalid = 1'b0;
    m_axi_arready = 1'b0; m_axi_rvalid = 1'b0;
  endtask

  // One command. Cycle 0 is the accept cycle; slave inputs for cycle n are set
  // mid-cycle n and the expected timing values are given by the caller.
  task automatic run_cmd(
    input string nm, input logic wr, input logic [11:0] addr,
    input logic [31:0] wd, input logic [3:0] ws,
    input int req_at, input int w_at, input int resp_at,
    input logic [1:0] resp, input logic [31:0] rd,
    input int exp_rsp_at, input int exp_cycles, input int exp_req_cnt,
    input int exp_w_cnt, input int exp_hs_first, input int exp_hs_cnt,
    input logic [31:0] exp_rdata, input int bp);
    int rsp_at = 0, req_cnt = 0, w_cnt = 0, hs_first = 0, hs_cnt = 0;
    int bad_fld = 0, bp_err = 0;
    logic [31:0] s_rdata;
    logic [1:0]  s_resp;
    logic [15:0] s_cyc;
    @(negedge aclk);
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wd; cmd_wstrb = ws;
    check({nm, "_cmd_ready_idle"}, cmd_ready, 1);
    for (int n = 1; (n <= 60) && (rsp_at == 0); n++) begin
      @(negedge aclk);
      cmd_valid = 1'b0;
      if (rsp_valid) begin
        rsp_at = n;
      end else begin
        if (wr) begin
          if (m_axi_awvalid) begin
            req_cnt++;
            if (m_axi_awaddr !== addr || m_axi_awprot !== 3'b000) bad_fld++;
          end
          if (m_axi_wvalid) begin
            w_cnt++;
            if (m_axi_wdata !== wd || m_axi_wstrb !== ws) bad_fld++;
          end
          if (m_axi_bready) begin
            if (hs_cnt == 0) hs_first = n;
            hs_cnt++;
          end
          if (m_axi_arvalid || m_axi_rready) bad_fld++;
        end else begin
          if (m_axi_arvalid) begin
            req_cnt++;
            if (m_axi_araddr !== addr || m_axi_arprot !== 3'b000) bad_fld++;
          end
          if (m_axi_wvalid) w_cnt++;
          if (m_axi_rready) begin
            if (hs_cnt == 0) hs_first = n;
            hs_cnt++;
          end
          if (m_axi_awvalid || m_axi_bready) bad_fld++;
        end
        m_axi_awready = wr && (n == req_at);
        m_axi_wready  = wr && (n == w_at);
        m_axi_bvalid  = wr && (n >= resp_at);
        m_axi_bresp   = resp;
        m_axi_arready = !wr && (n == req_at);
        m_axi_rvalid  = !wr && (n >= resp_at);
        m_axi_rresp   = resp;
        m_axi_rdata   = rd;
      end
    end
    slave_idle();
    check({nm, "_rsp_at"},   rsp_at,     exp_rsp_at);
    check({nm, "_rsp_resp"}, rsp_resp,   resp);
    check({nm, "_rsp_rdata"},rsp_rdata,  exp_rdata);
    check({nm, "_rsp_cyc"},  rsp_cycles, exp_cycles);
    check({nm, "_req_cnt"},  req_cnt,    exp_req_cnt);
    check({nm, "_w_cnt"},    w_cnt,      exp_w_cnt);
    check({nm, "_hs_first"}, hs_first,   exp_hs_first);
    check({nm, "_hs_cnt"},   hs_cnt,     exp_hs_cnt);
    check({nm, "_fields"},   bad_fld,    0);
    s_rdata = rsp_rdata; s_resp = rsp_resp; s_cyc = rsp_cycles;
    if (bp > 0) begin
      // hold the response while offering a competing command
      cmd_valid = 1'b1; cmd_write = !wr; cmd_addr = 12'h3F0;
      for (int k = 0; k < bp; k++) begin
        @(negedge aclk);
        if (!rsp_valid || rsp_rdata !== s_rdata || rsp_resp !== s_resp ||
            rsp_cycles !== s_cyc || cmd_ready || m_axi_awvalid ||
            m_axi_wvalid || m_axi_arvalid) bp_err++;
      end
      check({nm, "_bp_hold"}, bp_err, 0);
      cmd_valid = 1'b0;
    end
    rsp_ready = 1'b1;
    @(negedge aclk);
    rsp_ready = 1'b0;
    check({nm, "_post_cmd_ready"}, cmd_ready, 1);
    check({nm, "_post_rsp_valid"}, rsp_valid, 0);
  endtask

  initial begin
    // reset state
    repeat (3) @(negedge aclk);
    check("rst_valids", {m_axi_awvalid, m_axi_wvalid, m_axi_bready,
                         m_axi_arvalid, m_axi_rready, rsp_valid}, 0);
    check("rst_rsp", {rsp_rdata, rsp_resp, rsp_cycles}, 0);
    check("rst_cmd_ready", cmd_ready, 1);
    aresetn = 1'b1;

    // name wr addr wdata strb req w resp rsp rdata | rsp_at cyc req wcnt hs1 hscnt exp_rdata bp
    run_cmd("wr0", 1'b1, 12'h004, 32'hDEADBEEF, 4'hF, 1, 1, 2, 2'b00, 32'h0,
            3, 2, 1, 1, 2, 1, 32'h0, 0);
    run_cmd("wrskew", 1'b1, 12'h010, 32'hA5A50F0F, 4'h5, 1, 4, 7, 2'b00, 32'h0,
            8, 7, 1, 4, 5, 3, 32'h0, 0);
    run_cmd("rdwait", 1'b0, 12'h008, 32'h0, 4'h0, 3, 0, 6, 2'b00, 32'h12345678,
            7, 6, 3, 0, 4, 3, 32'h12345678, 0);
    run_cmd("rderr", 1'b0, 12'h00C, 32'h0, 4'h0, 1, 0, 2, 2'b10, 32'hCAFE0001,
            3, 2, 1, 0, 2, 1, 32'hCAFE0001, 5);
    run_cmd("wrerr", 1'b1, 12'h020, 32'h01020304, 4'h3, 1, 1, 2, 2'b11, 32'h0,
            3, 2, 1, 1, 2, 1, 32'h0, 5);

    // reset while the AW handshake is pending
    @(negedge aclk);
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 12'h044;
    cmd_wdata = 32'h55AA55AA; cmd_wstrb = 4'hF;
    @(negedge aclk);
    cmd_valid = 1'b0;
    check("rstmid_awvalid_pre", m_axi_awvalid, 1);
    @(negedge aclk);
    aresetn = 1'b0;
    @(negedge aclk);
    check("rstmid_valids", {m_axi_awvalid, m_axi_wvalid, m_axi_bready,
                            m_axi_arvalid, m_axi_rready, rsp_valid}, 0);
    check("rstmid_cmd_ready", cmd_ready, 1);
    aresetn = 1'b1;
    run_cmd("rdpost", 1'b0, 12'h030, 32'h0, 4'h0, 1, 0, 2, 2'b00, 32'h0BADF00D,
            3, 2, 1, 0, 2, 1, 32'h0BADF00D, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/axi4l_mst_cmd.md
# axi4l_mst_cmd

Command-driven AXI4-Lite master: the initiator counterpart of our AXI4-Lite register slaves. A simple valid/ready command port (one read or write per command) is converted into a single AXI4-Lite transaction. The bus response (read data, RESP code, transaction latency) returns on a valid/ready response port. Used by on-chip sequencers and test harnesses to drive register blocks; one transaction outstanding at a time.

## Interface
- C_ADDR_WIDTH, 12, byte address width of the command port and the AXI port
- C_DATA_WIDTH, 32, data width; only 32 or 64 allowed, any other value is an elaboration error
- aclk  in  1  clock; all logic rising-edge
- aresetn  in  1  reset, synchronous, active-low; clock aclk
- cmd_valid / cmd_ready  in / out  1  command handshake
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  C_ADDR_WIDTH  byte address, passed through unmodified
- cmd_wdata  in  C_DATA_WIDTH  write data; ignored for reads
- cmd_wstrb  in  C_DATA_WIDTH/8  byte strobes; ignored for reads
- rsp_valid / rsp_ready  out / in  1  response handshake
- rsp_rdata  out  C_DATA_WIDTH  read data; 0 for writes
- rsp_resp  out  2  captured RRESP or BRESP
- rsp_cycles  out  16  latency in cycles, saturating at 16'hFFFF
- m_axi_awaddr, awprot, awvalid / awready  AW channel; prot is always 3'b000
- m_axi_wdata, wstrb, wvalid / wready  W channel
- m_axi_bresp, bvalid / bready  B channel
- m_axi_araddr, arprot, arvalid / arready  AR channel; prot is always 3'b000
- m_axi_rdata, rresp, rvalid / rready  R channel

## Operation
- State machine has six states.
  - S_IDLE: cmd_ready=1. Accept when cmd_valid. Go to S_WREQ if cmd_write, else S_RREQ.
  - S_WREQ: awvalid and wvalid are asserted together on entry. Each channel is tracked independently: awvalid drops on the cycle after awready is sampled high, and wvalid does the same with wready. Go to S_WRESP once both handshakes have completed; this may happen in the same cycle.
  - S_WRESP: bready=1. On bvalid, capture bresp, set rdata=0, go to S_DONE.
  - S_RREQ: arvalid=1 until arready is sampled high, then go to S_RRESP.
  - S_RRESP: rready=1. On rvalid, capture rdata and rresp, go to S_DONE.
  - S_DONE: rsp_valid=1 with stable data. On rsp_ready, go to S_IDLE.
- Address, data and strobe are registered at command accept and held stable until their handshake completes. A valid is never dropped before its ready.
- bready and rready are asserted only in S_WRESP and S_RRESP respectively.
- rsp_cycles:
  - Cleared at command accept.
  - Increments in every cycle spent in S_WREQ, S_RREQ, S_WRESP or S_RRESP, including the capture cycle.
  - Frozen in S_DONE; saturates at 16'hFFFF with no wrap.
- SLVERR and DECERR are forwarded in rsp_resp unchanged. No retry.
- Reset: all outputs go to 0 and the state to S_IDLE, including mid-transaction. Valids drop immediately. The system resets slave and master together.

## Timing
- cmd_ready is combinational from state (S_IDLE only). All AXI valid and ready outputs and all rsp_* outputs are registered.
- Accept at cycle 0:
  - Write: awvalid=wvalid=1 at cycle 1. With zero-wait readies and bvalid, bready=1 at cycle 2, capture at 2, rsp_valid=1 at 3, rsp_cycles=2.
  - Read: arvalid=1 at cycle 1, rready=1 at cycle 2, capture at 2, rsp_valid=1 at 3, rsp_cycles=2.
- rsp_ready held high: S_DONE lasts 1 cycle and cmd_ready returns the next cycle. Minimum command interval is 4 cycles.
- rsp_ready low: rsp_valid and all rsp_* outputs are held. cmd_ready stays 0 and no new command is accepted.
- awready arrives k cycles before wready: awvalid drops and wvalid stays high. S_WRESP is entered the cycle after the wready handshake.

## Test plan
- Zero-wait write: addr 0x004, data 0xDEADBEEF, strb 0xF, slave awready=wready=bvalid=1, bresp 00 -> AW/W carry those values for exactly 1 cycle; rsp_valid at cycle 3; rsp_resp=00, rsp_rdata=0, rsp_cycles=2.
- Skewed write: awready at cycle 1, wready at cycle 4, bvalid at cycle 7 -> awvalid high only at cycle 1; wvalid high cycles 1-4 with wdata stable; bready high cycles 5-7; rsp_cycles=7.
- Read with wait: addr 0x008, arready at cycle 3, rvalid at cycle 6 with rdata 0x12345678, rresp 00 -> arvalid high cycles 1-3; rsp_rdata=0x12345678; rsp_cycles=6.
- Error passthrough: read returning rresp=10, then write returning bresp=11 -> rsp_resp=10 then 11; a new command is accepted only after each response is consumed.
- Backpressure: hold rsp_ready=0 for 5 cycles with cmd_valid held high -> rsp_* stable, cmd_ready=0 throughout, no new AR/AW/W issued; release -> cmd_ready=1 the next cycle.
- Reset mid-transaction: deassert aresetn while awvalid=1 and awready=0 -> the next cycle all valids, readies and rsp_valid are 0 with cmd_ready=1; a subsequent zero-wait read completes with rsp_cycles=2.
